// File: rtl/rr_resp_router.sv
// ============================================================================
// Module   : rr_resp_router
// Purpose  : Response return path for a round-robin arbitrated shared
//            resource. Records the one-hot grant of every issued request in
//            an in-order tracker. Steers each in-order response back to its
//            issuer with one cycle of registered latency.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            grant_oh_i         - one-hot grant of the request issued this cycle
//            issue_en           - a request is issued this cycle
//            issue_ready        - tracker not full (from registered count)
//            resp_valid         - response present this cycle
//            resp_data          - response payload
//            resp_valid_oh_o    - registered one-hot strobe to owning requester
//            resp_data_o        - registered payload, broadcast to requesters
//            outstanding_cnt    - entries currently held in the tracker
//            overflow_err       - sticky: issue dropped while full
//            underflow_err      - sticky: response arrived while empty
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_resp_router #(
  parameter int NUM_REQUESTERS  = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQUESTERS-1:0]            grant_oh_i,
  input  logic                                 issue_en,
  output logic                                 issue_ready,
  input  logic                                 resp_valid,
  input  logic [DATA_WIDTH-1:0]                resp_data,
  output logic [NUM_REQUESTERS-1:0]            resp_valid_oh_o,
  output logic [DATA_WIDTH-1:0]                resp_data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 overflow_err,
  output logic                                 underflow_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

  // Tracker storage: deliberately not reset, validity is carried by count_q.
  logic [NUM_REQUESTERS-1:0] mem_q [MAX_OUTSTANDING];

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q,  count_d;
  logic [NUM_REQUESTERS-1:0] strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0]     data_q,   data_d;
  logic                      ovf_q,    ovf_d;
  logic                      unf_q,    unf_d;

  logic has_grant;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign has_grant = |grant_oh_i;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign pop       = resp_valid && !empty;
  // A pop frees a slot in the same cycle, so a full tracker can still accept.
  assign push      = issue_en && has_grant && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    strobe_d = '0;
    data_d   = data_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    // Pointers wrap naturally because the depth is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      strobe_d = mem_q[rd_ptr_q];
      data_d   = resp_data;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (issue_en && has_grant && !push) begin
      ovf_d = 1'b1;
    end

    // An entry pushed in this same cycle is not bypassed to the response.
    if (resp_valid && empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= grant_oh_i;
    end
  end

  assign issue_ready     = !full;
  assign resp_valid_oh_o = strobe_q;
  assign resp_data_o     = data_q;
  assign outstanding_cnt = count_q;
  assign overflow_err    = ovf_q;
  assign underflow_err   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_resp_router.sv
// ============================================================================
// Module   : tb_rr_resp_router
// Purpose  : Self-checking bench for rr_resp_router. Combines directed
//            scenarios with randomized traffic. Checks are made against a
//            queue-based reference model of the response router.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_resp_router;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int DW = 32;
  localparam int CW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  grant_oh_i = '0;
  logic          issue_en = 1'b0;
  logic          issue_ready;
  logic          resp_valid = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic [N-1:0]  resp_valid_oh_o;
  logic [DW-1:0] resp_data_o;
  logic [CW-1:0] outstanding_cnt;
  logic          overflow_err;
  logic          underflow_err;

  rr_resp_router #(
    .NUM_REQUESTERS (N),
    .MAX_OUTSTANDING(M),
    .DATA_WIDTH     (DW)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .grant_oh_i     (grant_oh_i),
    .issue_en       (issue_en),
    .issue_ready    (issue_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_valid_oh_o(resp_valid_oh_o),
    .resp_data_o    (resp_data_o),
    .outstanding_cnt(outstanding_cnt),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the owners of outstanding requests, oldest first.
  logic [N-1:0]  m_q[$];
  logic [N-1:0]  m_strobe;
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_unf;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_strobe = '0;
    m_data   = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    do_pop  = resp_valid && (m_q.size() > 0);
    do_push = issue_en && (grant_oh_i != '0) && ((m_q.size() < M) || do_pop);
    if (resp_valid && m_q.size() == 0) m_unf = 1'b1;
    if (issue_en && (grant_oh_i != '0) && !do_push) m_ovf = 1'b1;
    if (do_pop) begin
      m_strobe = m_q.pop_front();
      m_data   = resp_data;
    end else begin
      m_strobe = '0;
    end
    if (do_push) m_q.push_back(grant_oh_i);
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".strobe"}, 64'(resp_valid_oh_o), 64'(m_strobe));
    check_val({ctx, ".data"},   64'(resp_data_o),     64'(m_data));
    check_val({ctx, ".cnt"},    64'(outstanding_cnt), 64'(m_q.size()));
    check_val({ctx, ".ready"},  64'(issue_ready),     64'(m_q.size() != M));
    check_val({ctx, ".ovf"},    64'(overflow_err),    64'(m_ovf));
    check_val({ctx, ".unf"},    64'(underflow_err),   64'(m_unf));
  endtask

  task automatic drive(input logic ie, input logic [N-1:0] g, input logic rv, input logic [DW-1:0] d);
    issue_en   = ie;
    grant_oh_i = g;
    resp_valid = rv;
    resp_data  = d;
  endtask

  task automatic cyc(input string ctx);
    model_step();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [N-1:0] seq [4];
    logic [N-1:0] g;
    int p_iss;
    int p_rsp;

    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b1000;
    seq[3] = 4'b0100;

    // Reset state.
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic single request.
    drive(1'b1, 4'b0100, 1'b0, '0);
    cyc("basic.issue");
    check_val("basic.cnt1", 64'(outstanding_cnt), 64'd1);
    drive(1'b0, '0, 1'b1, 32'hCAFE0001);
    cyc("basic.resp");
    check_val("basic.strobe", 64'(resp_valid_oh_o), 64'h4);
    check_val("basic.data", 64'(resp_data_o), 64'hCAFE0001);
    check_val("basic.cnt0", 64'(outstanding_cnt), 64'd0);
    drive(1'b0, '0, 1'b0, '0);
    cyc("basic.idle");

    // In-order routing, repeated to wrap the pointers.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, seq[i], 1'b0, '0);
        cyc("wrap.issue");
      end
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, '0, 1'b1, 32'hD000_0000 + DW'(rep * 16 + i));
        cyc("wrap.resp");
        check_val("wrap.order", 64'(resp_valid_oh_o), 64'(seq[i]));
      end
      drive(1'b0, '0, 1'b0, '0);
      cyc("wrap.idle");
    end

    // Full tracker, overflow, then push together with pop while full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0, '0);
      cyc("full.fill");
    end
    check_val("full.ready", 64'(issue_ready), 64'd0);
    drive(1'b1, 4'b0010, 1'b0, '0);
    cyc("full.drop");
    check_val("full.ovf", 64'(overflow_err), 64'd1);
    check_val("full.cnt", 64'(outstanding_cnt), 64'd4);
    drive(1'b1, 4'b0010, 1'b1, 32'hF000_0000);
    cyc("full.pushpop");
    check_val("full.pp_cnt", 64'(outstanding_cnt), 64'd4);
    check_val("full.pp_ready", 64'(issue_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 32'hF000_0001 + DW'(i));
      cyc("full.drain");
    end
    check_val("full.last", 64'(resp_valid_oh_o), 64'h2);

    // Underflow: lone response, then response with a same-cycle issue.
    drive(1'b0, '0, 1'b1, 32'hBAD0_0000);
    cyc("unf.alone");
    check_val("unf.set", 64'(underflow_err), 64'd1);
    check_val("unf.nostrobe", 64'(resp_valid_oh_o), 64'd0);
    drive(1'b1, 4'b0001, 1'b1, 32'hBAD0_0001);
    cyc("unf.withpush");
    check_val("unf.nobypass", 64'(resp_valid_oh_o), 64'd0);
    check_val("unf.cnt", 64'(outstanding_cnt), 64'd1);
    drive(1'b0, '0, 1'b1, 32'h1234_5678);
    cyc("unf.drain");

    // Zero grant is ignored; outputs hold while idle.
    drive(1'b1, 4'b0000, 1'b0, 32'hFFFF_FFFF);
    cyc("zero.g");
    cyc("zero.g2");
    check_val("zero.hold", 64'(resp_data_o), 64'h1234_5678);

    // Reset mid-flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq[i], 1'b0, '0);
      cyc("rst.fill");
    end
    drive(1'b0, '0, 1'b0, '0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 32'h0BAD_0BAD);
    cyc("rst.after");
    check_val("rst.unf", 64'(underflow_err), 64'd1);

    // Randomized traffic from a clean reset.
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int blk = 0; blk < 15; blk++) begin
      p_iss = int'($urandom_range(15, 90));
      p_rsp = int'($urandom_range(15, 90));
      for (int c = 0; c < 200; c++) begin
        g = ($urandom_range(0, 7) == 0) ? '0 : N'(1 << $urandom_range(0, N - 1));
        drive(int'($urandom_range(0, 99)) < p_iss, g,
              int'($urandom_range(0, 99)) < p_rsp, DW'($urandom));
        cyc("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
